// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_REQ requesters.
// Each access takes an ACCESS cycle and a DONE cycle. A locked owner may keep the port for up to LOCK_MAX grants in a row.
module data_memory_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      lock,
    input  logic [NUM_REQ-1:0]      we,
    input  logic [3*NUM_REQ-1:0]    reqFunc3,
    input  logic [32*NUM_REQ-1:0]   reqAddress,
    input  logic [32*NUM_REQ-1:0]   reqWriteData,
    output logic [NUM_REQ-1:0]      ack,
    output logic [31:0]             readDataOut,
    output logic                    busy,
    output logic [2:0]              grantId,
    output logic                    memoryReadEnable,
    output logic                    memoryWriteEnable,
    output logic [2:0]              memoryFunc3,
    output logic [31:0]             memoryAddress,
    output logic [31:0]             memoryWriteData,
    input  logic [31:0]             memoryReadData,
    output logic [1:0]              debugState
);
    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_grant_id;
    logic [LCW-1:0]     r_lock_count;
    logic [NUM_REQ-1:0] r_ack;
    logic [31:0]        r_read_data;
    logic               r_busy;
    logic               r_mem_re;
    logic               r_mem_we;
    logic [2:0]         r_mem_func3;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;

    logic [NUM_REQ-1:0] w_owner_mask;
    logic [NUM_REQ-1:0] w_eligible;
    logic               w_owner_relock;
    logic               w_found;
    logic [2:0]         w_winner;
    int                 w_pos;
    logic               w_sel_we;
    logic [2:0]         w_sel_func3;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;

    // In DONE the owner is excluded from the rotating search and may only win through an unexpired lock.
    always_comb begin
        w_owner_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_mask[i] = (r_grant_id == 3'(i));
        end
        w_owner_relock = (r_state == S_DONE) && (|(w_owner_mask & req & lock))
                         && (r_lock_count < LCW'(LOCK_MAX));
        w_eligible = (r_state == S_DONE) ? (req & ~w_owner_mask) : req;
        w_found    = 1'b0;
        w_winner   = r_grant_id;
        w_pos      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_pos = int'(r_grant_id) + off;
            if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && w_eligible[j] && (w_pos == j)) begin
                    w_found  = 1'b1;
                    w_winner = 3'(j);
                end
            end
        end
        if (w_owner_relock) begin
            w_found  = 1'b1;
            w_winner = r_grant_id;
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_func3 = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_winner == 3'(j)) begin
                w_sel_we    = we[j];
                w_sel_func3 = reqFunc3[3*j +: 3];
                w_sel_addr  = reqAddress[32*j +: 32];
                w_sel_wdata = reqWriteData[32*j +: 32];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_grant_id   <= 3'(NUM_REQ - 1);
            r_lock_count <= '0;
            r_ack        <= '0;
            r_read_data  <= '0;
            r_busy       <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_func3  <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_ACCESS: begin
                    if (r_mem_re) r_read_data <= memoryReadData;
                    r_mem_re <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_busy   <= 1'b0;
                    r_ack    <= w_owner_mask;
                    r_state  <= S_DONE;
                end
                default: begin
                    // IDLE and DONE both arbitrate; DONE falls back to IDLE when nobody wins.
                    if (w_found) begin
                        r_state      <= S_ACCESS;
                        r_busy       <= 1'b1;
                        r_grant_id   <= w_winner;
                        r_lock_count <= w_owner_relock ? (r_lock_count + 1'b1) : LCW'(1);
                        r_mem_re     <= !w_sel_we;
                        r_mem_we     <= w_sel_we;
                        r_mem_func3  <= w_sel_func3;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ack               = r_ack;
    assign readDataOut       = r_read_data;
    assign busy              = r_busy;
    assign grantId           = r_grant_id;
    assign memoryReadEnable  = r_mem_re;
    assign memoryWriteEnable = r_mem_we;
    assign memoryFunc3       = r_mem_func3;
    assign memoryAddress     = r_mem_addr;
    assign memoryWriteData   = r_mem_wdata;
    assign debugState        = r_state;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus randomized bursts checked against a transaction-level model.
module tb_data_memory_arbiter;
    localparam int N = 4;
    localparam int W = 103;  // {we, id[2:0], func3[2:0], addr[31:0], wdata[31:0], readDataOut[31:0]}

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req, lock, we;
    logic [3*N-1:0] reqFunc3;
    logic [32*N-1:0] reqAddress, reqWriteData;
    logic [N-1:0]   ack;
    logic [31:0]    readDataOut;
    logic           busy;
    logic [2:0]     grantId;
    logic           memoryReadEnable, memoryWriteEnable;
    logic [2:0]     memoryFunc3;
    logic [31:0]    memoryAddress, memoryWriteData, memoryReadData;
    logic [1:0]     debugState;

    logic [31:0]    mem [0:255];
    logic [W-1:0]   exp_q[$];
    int             n_checks = 0;
    int             n_fail = 0;

    // clock / memory model
    always #5 clock = ~clock;
    assign memoryReadData = mem[memoryAddress[9:2]];

    data_memory_arbiter #(.NUM_REQ(N), .LOCK_MAX(8)) dut (
        .clock(clock), .reset(reset), .req(req), .lock(lock), .we(we),
        .reqFunc3(reqFunc3), .reqAddress(reqAddress), .reqWriteData(reqWriteData),
        .ack(ack), .readDataOut(readDataOut), .busy(busy), .grantId(grantId),
        .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
        .memoryFunc3(memoryFunc3), .memoryAddress(memoryAddress),
        .memoryWriteData(memoryWriteData), .memoryReadData(memoryReadData),
        .debugState(debugState)
    );

    // driver tasks
    task automatic step();
        if (memoryWriteEnable === 1'b1) mem[memoryAddress[9:2]] = memoryWriteData;
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
        we[i] = w;
        reqFunc3[3*i +: 3] = f3;
        reqAddress[32*i +: 32] = a;
        reqWriteData[32*i +: 32] = d;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req = '0; lock = '0; we = '0;
        reqFunc3 = '0; reqAddress = '0; reqWriteData = '0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({ack, busy, memoryReadEnable, memoryWriteEnable, debugState} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack=%b busy=%b re=%b we=%b state=%0d, expected all 0",
                     ack, busy, memoryReadEnable, memoryWriteEnable, debugState);
        end
        n_checks++;
        if (grantId !== 3'd3) begin
            n_fail++; $display("FAIL reset_grantId: got %0d expected 3", grantId);
        end
        n_checks++;
        if (readDataOut !== 32'h0) begin
            n_fail++; $display("FAIL reset_readDataOut: got %h expected 0", readDataOut);
        end
        n_checks++;
        if ({memoryFunc3, memoryAddress, memoryWriteData} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: f3=%0d addr=%h wdata=%h expected 0",
                     memoryFunc3, memoryAddress, memoryWriteData);
        end
    endtask

    task automatic test_single_read();
        mem[4] = 32'hDEAD_BEEF;
        set_cmd(1, 1'b0, 3'b010, 32'h10, 32'h0);
        req[1] = 1'b1;
        step();
        n_checks++;
        if ({memoryReadEnable, memoryWriteEnable, busy, ack, grantId, memoryFunc3, memoryAddress}
            !== {1'b1, 1'b0, 1'b1, 4'b0000, 3'd1, 3'b010, 32'h10}) begin
            n_fail++;
            $display("FAIL single_read_access: re=%b we=%b busy=%b ack=%b gid=%0d f3=%0d addr=%h, expected 1 0 1 0000 1 2 10",
                     memoryReadEnable, memoryWriteEnable, busy, ack, grantId, memoryFunc3, memoryAddress);
        end
        step();
        n_checks++;
        if ({ack, memoryReadEnable, busy, debugState} !== {4'b0010, 1'b0, 1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL single_read_done: ack=%b re=%b busy=%b state=%0d, expected 0010 0 0 2",
                     ack, memoryReadEnable, busy, debugState);
        end
        n_checks++;
        if (readDataOut !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_read_data: got %h expected deadbeef", readDataOut);
        end
        req[1] = 1'b0;
        step();
        n_checks++;
        if ({ack, memoryReadEnable, memoryWriteEnable, debugState} !== '0 || readDataOut !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_read_idle: ack=%b re=%b we=%b state=%0d data=%h, expected idle holding deadbeef",
                     ack, memoryReadEnable, memoryWriteEnable, debugState, readDataOut);
        end
    endtask

    task automatic test_four_writes();
        int order[$];
        int when[$];
        int adj, got_id, got_c;
        logic prev_we;
        logic [2:0] prev_gid;
        apply_reset();
        for (int i = 0; i < N; i++) begin
            mem[i] = '0;
            set_cmd(i, 1'b1, 3'b010, 32'(4 * i), 32'h100 + 32'(i));
        end
        req = '1;
        adj = 0; prev_we = 1'b0; prev_gid = '0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (memoryWriteEnable && prev_we && grantId == prev_gid) adj++;
            prev_we = memoryWriteEnable; prev_gid = grantId;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin order.push_back(i); when.push_back(c); req[i] = 1'b0; end
            end
        end
        n_checks++;
        if (order.size() != 4) begin
            n_fail++; $display("FAIL four_writes_count: got %0d acks expected 4", order.size());
        end
        for (int k = 0; k < 4; k++) begin
            got_id = (k < order.size()) ? order[k] : -1;
            got_c  = (k < order.size()) ? when[k] : -1;
            n_checks++;
            if (got_id != k || got_c != 2 * (k + 1)) begin
                n_fail++;
                $display("FAIL four_writes_order[%0d]: got id %0d at cycle %0d, expected id %0d at cycle %0d",
                         k, got_id, got_c, k, 2 * (k + 1));
            end
            n_checks++;
            if (mem[k] !== 32'h100 + 32'(k)) begin
                n_fail++; $display("FAIL four_writes_mem[%0d]: got %h expected %h", k, mem[k], 32'h100 + 32'(k));
            end
        end
        n_checks++;
        if (adj != 0) begin
            n_fail++; $display("FAIL four_writes_adjacent: got %0d adjacent same-owner writes expected 0", adj);
        end
    endtask

    task automatic test_rotation();
        int order[$];
        set_cmd(2, 1'b0, 3'b010, 32'h20, 32'h0);
        req[2] = 1'b1;
        for (int c = 0; c < 8 && req[2]; c++) begin
            step();
            if (ack[2]) req[2] = 1'b0;
        end
        step();
        n_checks++;
        if (grantId !== 3'd2 || req[2] !== 1'b0) begin
            n_fail++; $display("FAIL rotation_setup: gid=%0d req2=%b expected gid 2 served", grantId, req[2]);
        end
        set_cmd(0, 1'b0, 3'b010, 32'h24, 32'h0);
        set_cmd(3, 1'b0, 3'b010, 32'h28, 32'h0);
        req[0] = 1'b1; req[3] = 1'b1;
        for (int c = 0; c < 12 && order.size() < 2; c++) begin
            step();
            for (int i = 0; i < N; i++) if (ack[i]) begin order.push_back(i); req[i] = 1'b0; end
        end
        n_checks++;
        if (order.size() != 2 || order[0] != 3 || order[1] != 0) begin
            n_fail++;
            $display("FAIL rotation_order: got %0d acks first=%0d second=%0d, expected 3 then 0",
                     order.size(), (order.size() > 0) ? order[0] : -1, (order.size() > 1) ? order[1] : -1);
        end
        req = '0;
    endtask

    task automatic test_lock_limit();
        int seq[$];
        int when[$];
        int expv;
        apply_reset();
        mem[16] = 32'hA5A5_0000;
        mem[17] = 32'h5A5A_1111;
        set_cmd(0, 1'b0, 3'b010, 32'h40, 32'h0);
        set_cmd(1, 1'b0, 3'b010, 32'h44, 32'h0);
        req[0] = 1'b1; lock[0] = 1'b1; req[1] = 1'b1;
        for (int c = 1; c <= 40 && seq.size() < 10; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    seq.push_back(i); when.push_back(c);
                    n_checks++;
                    if (readDataOut !== ((i == 1) ? 32'h5A5A_1111 : 32'hA5A5_0000)) begin
                        n_fail++; $display("FAIL lock_data: requester %0d got %h", i, readDataOut);
                    end
                    if (i == 1) req[1] = 1'b0;
                end
            end
            if (seq.size() == 10) begin req[0] = 1'b0; lock[0] = 1'b0; end
        end
        for (int k = 0; k < 10; k++) begin
            expv = (k == 8) ? 1 : 0;
            n_checks++;
            if (k >= seq.size() || seq[k] != expv) begin
                n_fail++;
                $display("FAIL lock_seq[%0d]: got %0d expected %0d", k, (k < seq.size()) ? seq[k] : -1, expv);
            end
        end
        n_checks++;
        if (when.size() != 10 || when[9] != 20) begin
            n_fail++;
            $display("FAIL lock_throughput: last ack at cycle %0d expected 20", (when.size() == 10) ? when[9] : -1);
        end
        repeat (3) step();
        n_checks++;
        if ({ack, debugState} !== '0) begin
            n_fail++; $display("FAIL lock_drain: ack=%b state=%0d expected idle", ack, debugState);
        end
    endtask

    task automatic test_drop_during_access();
        int acks, accesses;
        set_cmd(2, 1'b0, 3'b000, 32'h48, 32'h0);
        req[2] = 1'b1;
        step();
        n_checks++;
        if ({memoryReadEnable, grantId} !== {1'b1, 3'd2}) begin
            n_fail++; $display("FAIL drop_access: re=%b gid=%0d expected 1 2", memoryReadEnable, grantId);
        end
        req[2] = 1'b0;
        acks = 0; accesses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ack[2]) acks++;
            if (memoryReadEnable || memoryWriteEnable) accesses++;
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++; $display("FAIL drop_ack_count: got %0d acks expected 1", acks);
        end
        n_checks++;
        if (accesses != 0) begin
            n_fail++; $display("FAIL drop_reaccess: got %0d extra accesses expected 0", accesses);
        end
    endtask

    task automatic test_reset_mid_access();
        mem[20] = 32'h0000_0055;
        set_cmd(1, 1'b1, 3'b010, 32'h50, 32'hCAFE_F00D);
        req[1] = 1'b1;
        step();
        n_checks++;
        if ({memoryWriteEnable, grantId} !== {1'b1, 3'd1}) begin
            n_fail++; $display("FAIL rst_mid_setup: we=%b gid=%0d expected 1 1", memoryWriteEnable, grantId);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({memoryWriteEnable, busy, ack, grantId, debugState} !== {1'b0, 1'b0, 4'b0, 3'd3, 2'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_clear: we=%b busy=%b ack=%b gid=%0d state=%0d expected 0 0 0000 3 0",
                     memoryWriteEnable, busy, ack, grantId, debugState);
        end
        step();
        n_checks++;
        if (ack !== '0 || mem[20] !== 32'h0000_0055) begin
            n_fail++; $display("FAIL rst_mid_noack: ack=%b mem=%h expected 0000 and unwritten 55", ack, mem[20]);
        end
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 3'b010, 32'(4 * i), 32'h0);
        req = '1;
        step();
        n_checks++;
        if ({memoryReadEnable, grantId} !== {1'b1, 3'd0}) begin
            n_fail++; $display("FAIL rst_mid_restart: re=%b gid=%0d expected 1 0", memoryReadEnable, grantId);
        end
    endtask

    task automatic test_random(input int iter);
        logic        c_we   [N][12];
        logic [2:0]  c_f3   [N][12];
        logic [31:0] c_addr [N][12];
        logic [31:0] c_wd   [N][12];
        logic        c_lk   [N][12];
        logic [31:0] mm [16];
        int          cnt [N];
        int          nxt [N];
        int          hot, owner, lc, win, total, k;
        logic        first;
        logic [31:0] last_rd, rd;
        logic [W-1:0] e;
        apply_reset();
        exp_q.delete();
        hot = iter % N;
        for (int i = 0; i < N; i++) begin
            cnt[i] = (i == hot) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 6));
            nxt[i] = 0;
            for (int j = 0; j < 12; j++) begin
                c_we[i][j]   = 1'($urandom_range(0, 1));
                c_f3[i][j]   = 3'($urandom_range(0, 7));
                c_addr[i][j] = 32'(4 * $urandom_range(0, 15));
                c_wd[i][j]   = $urandom;
                c_lk[i][j]   = (i == hot) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
            end
        end
        for (int w = 0; w < 16; w++) begin mem[w] = $urandom; mm[w] = mem[w]; end

        // Reference model: whole transaction order from the round-robin and lock rules.
        total = 0;
        for (int i = 0; i < N; i++) total += cnt[i];
        owner = N - 1; lc = 0; first = 1'b1; last_rd = '0;
        for (int t = 0; t < total; t++) begin
            win = -1;
            if (!first && nxt[owner] < cnt[owner] && c_lk[owner][nxt[owner]] && lc < 8) begin
                win = owner; lc++;
            end else begin
                for (int off = 1; off < N; off++) begin
                    k = (owner + off) % N;
                    if (win < 0 && nxt[k] < cnt[k]) win = k;
                end
                if (win < 0) win = owner;
                lc = 1;
            end
            k = nxt[win];
            if (c_we[win][k]) begin
                rd = last_rd; mm[c_addr[win][k][5:2]] = c_wd[win][k];
            end else begin
                rd = mm[c_addr[win][k][5:2]]; last_rd = rd;
            end
            exp_q.push_back({c_we[win][k], 3'(win), c_f3[win][k], c_addr[win][k], c_wd[win][k], rd});
            nxt[win]++; owner = win; first = 1'b0;
        end

        for (int i = 0; i < N; i++) begin
            nxt[i] = 0;
            if (cnt[i] > 0) begin
                set_cmd(i, c_we[i][0], c_f3[i][0], c_addr[i][0], c_wd[i][0]);
                lock[i] = c_lk[i][0]; req[i] = 1'b1;
            end
        end
        for (int c = 0; c < 800 && exp_q.size() > 0; c++) begin
            step();
            if (memoryReadEnable || memoryWriteEnable) begin
                e = exp_q[0];
                n_checks++;
                if ({memoryReadEnable, memoryWriteEnable, grantId, memoryFunc3, memoryAddress}
                    !== {~e[102], e[102], e[101:99], e[98:96], e[95:64]}
                    || (e[102] && memoryWriteData !== e[63:32])) begin
                    n_fail++;
                    $display("FAIL random_access: re=%b we=%b gid=%0d f3=%0d addr=%h wd=%h expected we=%b gid=%0d f3=%0d addr=%h wd=%h",
                             memoryReadEnable, memoryWriteEnable, grantId, memoryFunc3, memoryAddress, memoryWriteData,
                             e[102], e[101:99], e[98:96], e[95:64], e[63:32]);
                end
            end
            if (ack != '0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (ack !== (4'b0001 << e[101:99]) || readDataOut !== e[31:0]) begin
                    n_fail++;
                    $display("FAIL random_ack: ack=%b data=%h expected requester %0d data=%h",
                             ack, readDataOut, e[101:99], e[31:0]);
                end
                for (int i = 0; i < N; i++) begin
                    if (ack[i]) begin
                        nxt[i]++;
                        if (nxt[i] < cnt[i]) begin
                            set_cmd(i, c_we[i][nxt[i]], c_f3[i][nxt[i]], c_addr[i][nxt[i]], c_wd[i][nxt[i]]);
                            lock[i] = c_lk[i][nxt[i]];
                        end else begin
                            req[i] = 1'b0; lock[i] = 1'b0;
                        end
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_drain[%0d]: %0d transactions never completed", iter, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req = '0; lock = '0; we = '0;
        reqFunc3 = '0; reqAddress = '0; reqWriteData = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        #2 reset = 1'b0;
        test_reset();
        test_single_read();
        test_four_writes();
        test_rotation();
        test_lock_limit();
        test_drop_during_access();
        test_reset_mid_access();
        for (int it = 0; it < 6; it++) test_random(it);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Round-robin arbiter that shares the single data memory port (`memoryReadEnable`/`memoryWriteEnable`/`func3`/`memoryAddress`/`writeData` → `readData`) among up to `NUM_REQ` requesters: the pipelined cores of the heterogeneous SoC and the FIR coefficient loader. It sits between the cores' memory-access stage and `dataMemory`. It serialises accesses with a request/acknowledge handshake and supports bounded locked bursts for atomic coefficient updates.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `LOCK_MAX`, 8: maximum consecutive locked grants to one requester before forced rotation.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `req`  in  NUM_REQ  access request, one bit per requester; held until `ack`.
- `lock`  in  NUM_REQ  requester asks to keep ownership for its next access.
- `we`  in  NUM_REQ  1 = write, 0 = read.
- `reqFunc3`  in  3*NUM_REQ  access size/sign code, packed (requester i at [3i+2:3i]).
- `reqAddress`  in  32*NUM_REQ  byte address, packed.
- `reqWriteData`  in  32*NUM_REQ  store data, packed.
- `ack`  out  NUM_REQ  one-cycle completion pulse to the served requester.
- `readDataOut`  out  32  read data, valid while `ack` is high.
- `busy`  out  1  high while an access is in ACCESS state.
- `grantId`  out  3  index of the current/last owner.
- `memoryReadEnable`, `memoryWriteEnable`  out  1 each  to data memory.
- `memoryFunc3`  out  3; `memoryAddress`  out  32; `memoryWriteData`  out  32.
- `memoryReadData`  in  32  combinational read data from data memory.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state IDLE.
- Arbitration: round-robin search starting at `grantId+1` (mod NUM_REQ) over asserted `req`. The winner's command is registered onto the memory outputs. `grantId` is updated and the FSM enters ACCESS.
- IDLE: arbitrate each edge; no request → stay IDLE.
- ACCESS: exactly one cycle. The selected enable is high (read xor write). At the closing edge, `memoryReadData` is captured into `readDataOut` for reads; for writes it holds its previous value. Enables are cleared and the FSM goes to DONE.
- DONE: `ack[grantId]` is high for this cycle only. Arbitration runs in the same cycle and excludes the current owner, except as a locked owner:
  - The current owner is eligible (and has priority) only if its `req` and `lock` are high and `lockCount < LOCK_MAX`.
  - If there is a winner, go to ACCESS; otherwise go to IDLE.
- `lockCount`:
  - Set to 1 on a grant to a new owner.
  - Incremented on each consecutive locked re-grant.
  - Cleared when the owner changes.
  - Saturates at LOCK_MAX; at LOCK_MAX the owner is excluded from that DONE arbitration.
- Starvation bound: a waiting requester is served within (NUM_REQ-1)*LOCK_MAX transactions.
- Requesters must hold `we`/`reqFunc3`/`reqAddress`/`reqWriteData` stable while `req` is high.
  - `req` dropped during ACCESS: the access still completes and `ack` is still issued.
  - `req` dropped before grant: no access occurs.
- `lock` is sampled only at DONE arbitration; in IDLE it is ignored for priority.

## Timing
- Reset values:
  - all outputs 0;
  - `grantId` = NUM_REQ-1, so requester 0 has first priority;
  - `lockCount` = 0; FSM in IDLE.
- Reset asserted mid-ACCESS or mid-DONE: outputs clear immediately (asynchronous), with no pending `ack`. The aborted access is not retried.
- Latency from IDLE: `req` seen at edge k → memory enable high in cycle k..k+1 → `ack` and `readDataOut` valid in cycle k+1..k+2.
- Back-to-back throughput: one access per 2 cycles while requests are pending. IDLE is not revisited between accesses.
- Simultaneous requests: served in round-robin order from `grantId+1`.
- A requester seeing `ack` must drop `req` or present a new command by the next edge. Its still-high `req` during DONE is not counted as a new request unless it is locked.
- Wrap-around: the search index wraps from NUM_REQ-1 to 0.

## Test plan
- Single read:
  - Stimulus: after reset, `req[1]`=1, `we[1]`=0, addr 0x0000_0010, memory returns 0xDEAD_BEEF.
  - Required: `memoryReadEnable`=1 with address 0x10 one cycle after sampling; `ack[1]` one cycle later with `readDataOut`=0xDEAD_BEEF; `grantId`=1.
- Four simultaneous writes:
  - Stimulus: requester i writes 0x100+i to address 4i, all issued in the same cycle.
  - Required: order 0,1,2,3; acks at relative cycles 2,4,6,8; `memoryWriteEnable` never high in adjacent cycles with the same owner.
- Rotation:
  - Stimulus: serve requester 2, then assert `req[0]` and `req[3]` together.
  - Required: 3 is served before 0.
- Lock limit:
  - Stimulus: `req[0]`/`lock[0]` held high issuing continuous reads; `req[1]` raised.
  - Required: requester 0 gets exactly 8 consecutive grants, then requester 1 is served, then requester 0 again.
- Reset mid-ACCESS:
  - Stimulus: pull `reset` low during a write's ACCESS cycle.
  - Required: `memoryWriteEnable` drops immediately and no `ack` is issued. After release, with all requests high, requester 0 wins first.
- Drop during ACCESS:
  - Stimulus: `req[2]` deasserted in its ACCESS cycle.
  - Required: `ack[2]` is still pulsed once, and there is no second access for requester 2.
